sub_32bits_seq: RTL and testbench

- Multi-cycle 32-bit subtractor with borrow: computes d = a - b - bi, processing one 4-bit slice per clock, LSB slice first.
- Complement of the combinational carry-select adder in the CPU datapath.
- Serves multi-cycle ALU ops (compare/subtract-with-borrow) where area matters more than latency.
- Start/done handshake. Result and flags are held stable until the next result completes.

---
 rtl/sub_32bits_seq.sv | 121 ++++++++++++
 tb/tb_sub_32bits_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sub_32bits_seq.sv
// Multi-cycle subtractor with borrow: d = a - b - bi, one STEP-bit slice per clock,
// LSB slice first, with a start/done handshake and result flags held until the next result.
module sub_32bits_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTEP = WIDTH / STEP;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    // Only the low NSTEP-1 slices are stored; the last slice joins them on the final edge.
    logic [WIDTH-STEP-1:0] acc_r;
    logic             borrow_r;
    logic             a_sign;
    logic             b_sign;
    logic [CNT_W-1:0] cnt;

    logic [STEP:0]    slice;
    logic [STEP-1:0]  nib;
    logic             br;
    logic [WIDTH-1:0] acc_final;

    // One slice of the borrow chain: (STEP+1)-bit difference, MSB is the borrow out.
    function automatic logic [STEP:0] slice_sub(input logic [STEP-1:0] x,
                                                input logic [STEP-1:0] y,
                                                input logic            bin);
        slice_sub = {1'b0, x} - {1'b0, y} - {{STEP{1'b0}}, bin};
    endfunction

    always_comb begin
        slice     = slice_sub(a_r[STEP-1:0], b_r[STEP-1:0], borrow_r);
        nib       = slice[STEP-1:0];
        br        = slice[STEP];
        acc_final = {nib, acc_r};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            d        <= '0;
            bo       <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
            borrow_r <= 1'b0;
            a_sign   <= 1'b0;
            b_sign   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        borrow_r <= bi;
                        a_sign   <= a[WIDTH-1];
                        b_sign   <= b[WIDTH-1];
                        acc_r    <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_r      <= {{STEP{1'b0}}, a_r[WIDTH-1:STEP]};
                    b_r      <= {{STEP{1'b0}}, b_r[WIDTH-1:STEP]};
                    acc_r    <= acc_final[WIDTH-1:STEP];
                    borrow_r <= br;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Result and flags change only here, on the edge that raises done.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        d     <= acc_final;
                        bo    <= br;
                        zero  <= (acc_final == '0);
                        ovf   <= (a_sign != b_sign) && (acc_final[WIDTH-1] != a_sign);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_32bits_seq.sv
// Directed bench for sub_32bits_seq: hand-computed vectors, latency, handshake and reset cases.
module tb_sub_32bits_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic        busy;
    logic        done;
    logic [31:0] d;
    logic        bo;
    logic        ovf;
    logic        zero;

    int n_checks;
    int n_pass;

    sub_32bits_seq #(.WIDTH(32), .STEP(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bi   (bi),
        .busy (busy),
        .done (done),
        .d    (d),
        .bo   (bo),
        .ovf  (ovf),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges from the accepting edge until done is seen, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            step();
            edges++;
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic biv, input logic [31:0] ed, input logic ebo,
                          input logic eovf, input logic ezero);
        int edges;
        a = av; b = bv; bi = biv; start = 1'b1;
        step();
        start = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; bi = 1'b1;
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(edges);
        chk({name, "_lat"}, edges, 32'd8);
        chk({name, "_d"}, d, ed);
        chk({name, "_bo"}, {31'd0, bo}, {31'd0, ebo});
        chk({name, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        chk({name, "_zero"}, {31'd0, zero}, {31'd0, ezero});
        step();
        chk({name, "_pulse"}, {31'd0, done}, 32'd0);
        chk({name, "_hold"}, d, ed);
    endtask

    initial begin
        int  edges;
        logic seen;
        logic held;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_flags", {29'd0, bo, ovf, zero}, 32'd0);
        rst = 1'b0;
        step();

        run_op("basic", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op("wrap", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op("sovf", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op("bizero", 32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);

        // start during RUN must be ignored
        a = 32'd10; b = 32'd4; bi = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 32'd1; b = 32'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(edges);
        chk("ign_lat", edges + 2, 32'd8);
        chk("ign_d", d, 32'd6);
        step();
        chk("ign_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of a RUN
        a = 32'd10; b = 32'd4; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_d", d, 32'd0);
        chk("mrst_flags", {29'd0, bo, ovf, zero}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen = 1'b1;
            step();
        end
        chk("mrst_nodone", {31'd0, seen}, 32'd0);

        // reset and start together: start dropped
        a = 32'd3; b = 32'd1; start = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rststart_busy", {31'd0, busy}, 32'd0);
        step();
        chk("rststart_idle", {31'd0, busy}, 32'd0);

        // back-to-back operation with start held high
        a = 32'hFFFF_FFFF; b = 32'd1; bi = 1'b0; start = 1'b1;
        step();
        wait_done(edges);
        chk("b2b1_lat", edges, 32'd8);
        chk("b2b1_d", d, 32'hFFFF_FFFE);
        chk("b2b1_bo", {31'd0, bo}, 32'd0);
        a = 32'd7; b = 32'd9;
        step();
        start = 1'b0;
        chk("b2b_rerun", {30'd0, busy, done}, 32'd2);
        held = 1'b1;
        edges = 1;
        while (!done && edges < 20) begin
            if (d !== 32'hFFFF_FFFE) held = 1'b0;
            step();
            edges++;
        end
        chk("b2b_held", {31'd0, held}, 32'd1);
        chk("b2b2_gap", edges, 32'd9);
        chk("b2b2_d", d, 32'hFFFF_FFFE);
        chk("b2b2_bo", {31'd0, bo}, 32'd1);
        chk("b2b2_ovf", {31'd0, ovf}, 32'd0);
        step();
        chk("b2b2_end", {30'd0, busy, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
